// File: rtl/mem_resp_ram_if.sv
// Request/response channel between the core's access unit (master) and mem_resp_ram (slave).
// Both directions use an independent valid/ready handshake.
interface mem_resp_ram_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        req_wen;
  logic [1:0]  req_size;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_size, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_size, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_resp_ram.sv
// Byte-addressed load/store responder over a single-port 64-bit word array.
// An access that straddles two words is split into two array beats.
module mem_resp_ram #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter logic [63:0] BASE       = 64'h0000_0000_8000_0000
) (
  input logic           clk,
  input logic           rst_n,
  mem_resp_ram_if.slave bus
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {StIdle, StBeat1, StBeat2, StResp} state_e;

  state_e state_q, state_d;

  logic [DEPTH_LOG2-1:0] idx_q;
  logic [2:0]            off_q;
  logic [1:0]            size_q;
  logic                  wen_q;
  logic [63:0]           wdata_q;
  logic                  cross_q;
  logic                  err_q;
  logic [63:0]           rd_q;
  logic [63:0]           w1_q;
  logic [63:0]           mem [Depth];

  // Decode of the incoming request, used only at the accept edge.
  logic [63:0] rel;
  logic [3:0]  n_bytes;
  logic [64:0] end_addr;
  logic        acc_err;
  logic        acc_cross;
  logic        accept;

  assign rel       = bus.req_addr - BASE;
  assign n_bytes   = 4'd1 << bus.req_size;
  // 65-bit sum so that a wrapped rel (addr below BASE) cannot alias into range.
  assign end_addr  = {1'b0, rel} + 65'(n_bytes);
  assign acc_err   = end_addr > (65'd8 << DEPTH_LOG2);
  assign acc_cross = ({1'b0, rel[2:0]} + n_bytes) > 4'd8;
  assign accept    = (state_q == StIdle) && bus.req_valid;

  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= rel[DEPTH_LOG2+2:3];
      off_q   <= rel[2:0];
      size_q  <= bus.req_size;
      wen_q   <= bus.req_wen;
      wdata_q <= bus.req_wdata;
      cross_q <= acc_cross;
      err_q   <= acc_err;
    end
  end

  // Beat datapath: align store data and byte enables across the two-word window.
  logic                  in_beat;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_idx;
  logic [3:0]            n_q;
  logic [7:0]            nmask;
  logic [15:0]           be_wide;
  logic [127:0]          wd_wide;
  logic [7:0]            beat_be;
  logic [63:0]           beat_wd;

  assign in_beat = (state_q == StBeat1) || (state_q == StBeat2);
  // A reset landing on a beat edge drops that beat's write.
  assign mem_we  = rst_n && wen_q && in_beat;
  assign mem_idx = (state_q == StBeat2) ? idx_q + DEPTH_LOG2'(1) : idx_q;
  assign n_q     = 4'd1 << size_q;
  assign nmask   = 8'hFF >> (4'd8 - n_q);
  assign be_wide = {8'b0, nmask} << off_q;
  assign wd_wide = {64'b0, wdata_q} << {off_q, 3'b000};
  assign beat_be = (state_q == StBeat2) ? be_wide[15:8]   : be_wide[7:0];
  assign beat_wd = (state_q == StBeat2) ? wd_wide[127:64] : wd_wide[63:0];

  always_ff @(posedge clk) begin
    if (in_beat) begin
      if (mem_we) begin
        for (int b = 0; b < 8; b++) begin
          if (beat_be[b]) mem[mem_idx][8*b +: 8] <= beat_wd[8*b +: 8];
        end
      end
      rd_q <= mem[mem_idx];
    end
    if (state_q == StBeat2) w1_q <= rd_q;
  end

  // Load merge: after a crossing access w1_q holds word 1 and rd_q word 2.
  logic [127:0] pair;
  logic [63:0]  shifted;
  logic [63:0]  data_mask;

  assign pair    = cross_q ? {rd_q, w1_q} : {64'b0, rd_q};
  assign shifted = 64'(pair >> {off_q, 3'b000});

  always_comb begin
    data_mask = '0;
    for (int b = 0; b < 8; b++) data_mask[8*b +: 8] = {8{nmask[b]}};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.req_valid) state_d = acc_err ? StResp : StBeat1;
      StBeat1: state_d = cross_q ? StBeat2 : StResp;
      StBeat2: state_d = StResp;
      StResp:  if (bus.resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.resp_valid = (state_q == StResp);
  assign bus.resp_err   = (state_q == StResp) && err_q;
  assign bus.resp_rdata = ((state_q == StResp) && !err_q && !wen_q) ? (shifted & data_mask) : '0;

endmodule

// File: tb/tb_mem_resp_ram.sv
// Directed bench for mem_resp_ram: stores, loads, word-crossing accesses, range errors,
// response back-pressure and reset in the middle of a crossing store.
module tb_mem_resp_ram;

  localparam logic [63:0] Base = 64'h0000_0000_8000_0000;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  mem_resp_ram_if bus_if ();

  mem_resp_ram #(
    .DEPTH_LOG2 (12),
    .BASE       (Base)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Issue one request from idle and consume its response; lat counts edges after accept.
  task automatic do_req(input logic [63:0] addr, input logic wen, input logic [1:0] size,
                        input logic [63:0] wdata, output logic [63:0] rdata,
                        output logic err, output int lat);
    bus_if.req_addr  = addr;
    bus_if.req_wen   = wen;
    bus_if.req_size  = size;
    bus_if.req_wdata = wdata;
    bus_if.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
    lat = 1;
    while (!bus_if.resp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus_if.resp_valid) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout: no response for addr 0x%016h", addr);
    end
    rdata = bus_if.resp_rdata;
    err   = bus_if.resp_err;
    bus_if.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.resp_ready = 1'b0;
  endtask

  task automatic store(input logic [63:0] addr, input logic [1:0] size, input logic [63:0] wd);
    logic [63:0] rd;
    logic        er;
    int          lt;
    do_req(addr, 1'b1, size, wd, rd, er, lt);
  endtask

  task automatic load_check(input string tag, input logic [63:0] addr, input logic [1:0] size,
                            input logic [63:0] exp);
    logic [63:0] rd;
    logic        er;
    int          lt;
    do_req(addr, 1'b0, size, 64'd0, rd, er, lt);
    check_eq(tag, rd, exp);
    check_eq({tag, "_err"}, 64'(er), 64'd0);
  endtask

  task automatic err_check(input string tag, input logic [63:0] addr, input logic wen,
                           input logic [1:0] size);
    logic [63:0] rd;
    logic        er;
    int          lt;
    do_req(addr, wen, size, 64'hDEAD_BEEF_DEAD_BEEF, rd, er, lt);
    check_eq({tag, "_err"},   64'(er), 64'd1);
    check_eq({tag, "_lat"},   64'(lt), 64'd1);
    check_eq({tag, "_rdata"}, rd,      64'd0);
  endtask

  initial begin
    logic [63:0] rd;
    logic        er;
    int          lt;
    int          bound;

    n_checks = 0;
    n_errors = 0;
    rst_n             = 1'b0;
    bus_if.req_valid  = 1'b0;
    bus_if.req_addr   = '0;
    bus_if.req_wen    = 1'b0;
    bus_if.req_size   = '0;
    bus_if.req_wdata  = '0;
    bus_if.resp_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req_ready",  64'(bus_if.req_ready),  64'd1);
    check_eq("rst_resp_valid", 64'(bus_if.resp_valid), 64'd0);
    check_eq("rst_resp_err",   64'(bus_if.resp_err),   64'd0);
    check_eq("rst_resp_rdata", bus_if.resp_rdata,      64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Aligned 8-byte store and load.
    do_req(Base, 1'b1, 2'd3, 64'h1122_3344_5566_7788, rd, er, lt);
    check_eq("st8_lat", 64'(lt), 64'd2);
    check_eq("st8_err", 64'(er), 64'd0);
    do_req(Base, 1'b0, 2'd3, 64'd0, rd, er, lt);
    check_eq("ld8_data", rd, 64'h1122_3344_5566_7788);
    check_eq("ld8_err",  64'(er), 64'd0);
    check_eq("ld8_lat",  64'(lt), 64'd2);

    // Crossing 4-byte store at offset 6.
    store(Base,        2'd3, 64'd0);
    store(Base + 64'd8, 2'd3, 64'd0);
    do_req(Base + 64'd6, 1'b1, 2'd2, 64'h0000_0000_AABB_CCDD, rd, er, lt);
    check_eq("xst_lat",  64'(lt), 64'd3);
    check_eq("xst_data", rd,      64'd0);
    load_check("xst_w0", Base,         2'd3, 64'hCCDD_0000_0000_0000);
    load_check("xst_w1", Base + 64'd8, 2'd3, 64'h0000_0000_0000_AABB);
    do_req(Base + 64'd6, 1'b0, 2'd2, 64'd0, rd, er, lt);
    check_eq("xld_data", rd,      64'h0000_0000_AABB_CCDD);
    check_eq("xld_lat",  64'(lt), 64'd3);

    // Narrow loads are zero-extended.
    store(Base + 64'h10, 2'd3, 64'hFFFF_FFFF_FFFF_FF80);
    load_check("ld1_zext", Base + 64'h10, 2'd0, 64'h80);
    load_check("ld2_zext", Base + 64'h11, 2'd1, 64'hFFFF);

    // Back-pressure: hold resp_ready low with req_valid asserted.
    bus_if.req_addr  = Base + 64'h10;
    bus_if.req_wen   = 1'b0;
    bus_if.req_size  = 2'd3;
    bus_if.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bound = 0;
    while (!bus_if.resp_valid && bound < 20) begin
      @(posedge clk);
      #1;
      bound++;
    end
    check_eq("bp_valid0", 64'(bus_if.resp_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_eq("bp_valid", 64'(bus_if.resp_valid), 64'd1);
      check_eq("bp_rdata", bus_if.resp_rdata,      64'hFFFF_FFFF_FFFF_FF80);
      check_eq("bp_ready", 64'(bus_if.req_ready),  64'd0);
    end
    bus_if.req_valid  = 1'b0;
    bus_if.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.resp_ready = 1'b0;
    check_eq("bp_ready_after", 64'(bus_if.req_ready),  64'd1);
    check_eq("bp_valid_after", 64'(bus_if.resp_valid), 64'd0);

    // Out-of-range accesses must not touch the array.
    store(Base + 64'h7FF8, 2'd3, 64'h5555_AAAA_5555_AAAA);
    err_check("e_below",  64'h7FFF_FFF8,    1'b1, 2'd3);
    err_check("e_xlast",  Base + 64'h7FFE,  1'b1, 2'd2);
    err_check("e_past",   Base + 64'h8000,  1'b0, 2'd3);
    load_check("e_lastword", Base + 64'h7FF8, 2'd3, 64'h5555_AAAA_5555_AAAA);
    load_check("e_word0",    Base,            2'd3, 64'hCCDD_0000_0000_0000);

    // Reset during BEAT2 of a crossing 8-byte store.
    store(Base,         2'd3, 64'd0);
    store(Base + 64'd8, 2'd3, 64'h0123_4567_89AB_CDEF);
    bus_if.req_addr  = Base + 64'd4;
    bus_if.req_wen   = 1'b1;
    bus_if.req_size  = 2'd3;
    bus_if.req_wdata = 64'hA1A2_A3A4_A5A6_A7A8;
    bus_if.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("mid_rst_ready", 64'(bus_if.req_ready),  64'd1);
    check_eq("mid_rst_valid", 64'(bus_if.resp_valid), 64'd0);
    load_check("mid_rst_w0", Base,         2'd3, 64'hA5A6_A7A8_0000_0000);
    load_check("mid_rst_w1", Base + 64'd8, 2'd3, 64'h0123_4567_89AB_CDEF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
